mole_scheduler: RTL
===================

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 SHALL have parameter UP_TICKS, default 8: ticks a mole stays up.
REQ-002 SHALL have parameter GAP_TICKS, default 2: ticks between moles.
REQ-003 SHALL have parameter MAX_MISSES, default 3: misses that end the game.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse, begins a game.
REQ-007 SHALL have port tick  input  1  one-cycle timing enable from rate divider.
REQ-008 SHALL have port whack  input  4  synchronized one-cycle key pulses, bit i = hole i.
REQ-009 SHALL have port mole  output  4  one-hot active hole, 0 when no mole up.
REQ-010 SHALL have port score  output  8  hit count.
REQ-011 SHALL have port misses  output  2  miss count.
REQ-012 SHALL have port hit_pulse  output  1  one cycle per hit.
REQ-013 SHALL have port miss_pulse  output  1  one cycle per miss.
REQ-014 SHALL have port game_over  output  1  high while in OVER.

Function
REQ-015 SHALL implement states IDLE, SPAWN, UP, HIT, MISS, GAP, OVER.
REQ-016 IDLE/OVER: start -> SPAWN, clear score and misses same edge; start ignored in all other states.
REQ-017 SHALL run a free-running 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, advancing every clock.
REQ-018 SPAWN (one cycle): hole = lfsr[1:0]; if equal to previous hole use (hole+1) mod 4; load up counter with UP_TICKS; -> UP.
REQ-019 UP: mole = one-hot(hole); up counter decrements on tick only.
REQ-020 UP: whack bit for the active hole -> HIT next cycle; takes priority over timeout and over wrong-hole bits in the same cycle.
REQ-021 UP: tick with up counter == 1 and no correct whack -> MISS.
REQ-022 HIT (one cycle): hit_pulse=1, score+1 saturating at 255, -> GAP.
REQ-023 MISS (one cycle): miss_pulse=1, misses+1; if new count == MAX_MISSES -> OVER else -> GAP.
REQ-024 GAP: mole=0, whack ignored, gap counter loaded GAP_TICKS on entry, -> SPAWN on tick when counter == 1.
REQ-025 OVER: game_over=1, mole=0, score and misses held.
REQ-026 mole SHALL be 0 in every state except UP.
REQ-027 whack outside UP SHALL have no effect.
REQ-028 SHALL require UP_TICKS>=1, GAP_TICKS>=1, 1<=MAX_MISSES<=3.

Reset
REQ-029 resetn low SHALL immediately force IDLE, mole=0, score=0, misses=0, hit_pulse=0, miss_pulse=0, game_over=0, counters=0, previous hole=0.
REQ-030 resetn low SHALL load LFSR with 8'hA5.
REQ-031 Reset mid-game SHALL abandon the round; no pulse emitted.

Configuration
REQ-032 Macro WRONG_WHACK_PENALTY_EN defined: in UP, a whack with no correct-hole bit and any other bit set -> MISS, same as timeout.
REQ-033 Macro undefined: wrong-hole whacks in UP are ignored; mole stays up until hit or timeout.

Verification
REQ-034 Reset, start, whack correct hole on 3rd tick of UP -> hit_pulse one cycle, score=1, mole=0 for 2 ticks, then new one-hot mole in a different hole.
REQ-035 Start, no whacks, UP_TICKS=8 -> miss_pulse after 8th tick; after 3 rounds misses=3, game_over=1, mole=0.
REQ-036 Correct whack and final tick in same cycle -> HIT, score+1, misses unchanged.
REQ-037 Wrong-hole whack in UP -> with WRONG_WHACK_PENALTY_EN misses+1; without it no change, mole still shown.
REQ-038 resetn low mid-UP with score=5 -> all outputs 0 asynchronously; start after release -> SPAWN, score=0.
REQ-039 Force 256 consecutive hits -> score stays 255, hit_pulse still asserted per hit.

Source files
------------

// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole round sequencer with LFSR-driven hole selection.
// Optional feature macro WRONG_WHACK_PENALTY_EN: a wrong-hole whack while a mole is up counts as a miss.
module mole_scheduler #(
    parameter int UP_TICKS   = 8,
    parameter int GAP_TICKS  = 2,
    parameter int MAX_MISSES = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       tick,
    input  logic [3:0] whack,
    output logic [3:0] mole,
    output logic [7:0] score,
    output logic [1:0] misses,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       game_over
);

    // Legal range: UP_TICKS >= 1, GAP_TICKS >= 1, 1 <= MAX_MISSES <= 3.
    localparam int                CNT_W    = $clog2((UP_TICKS > GAP_TICKS ? UP_TICKS : GAP_TICKS) + 1);
    localparam logic [CNT_W-1:0]  UP_LOAD  = CNT_W'(UP_TICKS);
    localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [1:0]        MISS_LIM = 2'(MAX_MISSES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_UP,
        S_HIT,
        S_MISS,
        S_GAP,
        S_OVER
    } state_t;

    state_t           state;
    logic [7:0]       lfsr;
    logic             lfsr_fb;
    logic [1:0]       hole;
    logic [1:0]       spawn_hole;
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic             correct_whack;
    logic             wrong_whack;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting toward the MSB.
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // `hole` still holds the previous round's hole while in SPAWN, so a repeat is bumped by one.
    assign spawn_hole = (lfsr[1:0] == hole) ? lfsr[1:0] + 2'd1 : lfsr[1:0];

    assign correct_whack = whack[hole];

`ifdef WRONG_WHACK_PENALTY_EN
    // The correct-hole case is tested first, so any remaining set bit is a wrong hole.
    assign wrong_whack = |whack;
`else
    assign wrong_whack = 1'b0;
`endif

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    // NOTE: every register, including the previous-hole and counters, has an explicit reset value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            hole       <= 2'd0;
            up_cnt     <= '0;
            gap_cnt    <= '0;
            mole       <= 4'd0;
            score      <= 8'd0;
            misses     <= 2'd0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state     <= S_SPAWN;
                        score     <= 8'd0;
                        misses    <= 2'd0;
                        game_over <= 1'b0;
                    end
                end
                S_SPAWN: begin
                    hole   <= spawn_hole;
                    up_cnt <= UP_LOAD;
                    mole   <= 4'b0001 << spawn_hole;
                    state  <= S_UP;
                end
                S_UP: begin
                    if (correct_whack) begin
                        mole      <= 4'd0;
                        hit_pulse <= 1'b1;
                        if (score != 8'hFF) begin
                            score <= score + 8'd1;
                        end
                        state <= S_HIT;
                    end else if (wrong_whack || (tick && up_cnt == CNT_ONE)) begin
                        mole       <= 4'd0;
                        miss_pulse <= 1'b1;
                        misses     <= misses + 2'd1;
                        state      <= S_MISS;
                    end else if (tick) begin
                        up_cnt <= up_cnt - CNT_ONE;
                    end
                end
                S_HIT: begin
                    gap_cnt <= GAP_LOAD;
                    state   <= S_GAP;
                end
                S_MISS: begin
                    gap_cnt <= GAP_LOAD;
                    if (misses == MISS_LIM) begin
                        game_over <= 1'b1;
                        state     <= S_OVER;
                    end else begin
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (gap_cnt == CNT_ONE) begin
                            state <= S_SPAWN;
                        end else begin
                            gap_cnt <= gap_cnt - CNT_ONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
